count_ctrl: RTL and testbench

Control and counting stage of the count game; sits directly upstream of the seven-segment decode/display stage and feeds it one BCD digit at a time.
- Debounces the start/stop button and runs an IDLE/RUN/PAUSE/DONE state machine.
- Keeps a 4-digit BCD tick counter (0000-9999).
- Time-multiplexes the four digits onto a single num[3:0] output, with a matching position index for digit enables.

---
 rtl/count_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_count_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: control and counting stage of the count game.
// Debounces the start/stop button, runs the IDLE/RUN/PAUSE/DONE machine,
// keeps a 4-digit BCD tick counter and scans one digit at a time onto num/pos.
`timescale 1ns/1ps

module count_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int SCAN_DIV   = 10000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    input  logic       clr,
    output logic [3:0] num,
    output logic [1:0] pos,
    output logic       running,
    output logic       done
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    logic          st_meta_q, st_sync_q;
    logic [DW-1:0] deb_cnt_q;
    logic          deb_lvl_q;
    logic          press_q;

    state_e        state_q, state_d;
    logic [15:0]   digits_q, digits_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    logic [SW-1:0] scan_cnt_q;
    logic          scan_last;
    logic [1:0]    pos_q, pos_d;
    logic [3:0]    num_q;
    logic          running_q, done_q;

    // Ripple-carry BCD increment; digits that reach 9 wrap to 0 and carry up.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser for the raw button.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_meta_q <= 1'b0;
            st_sync_q <= 1'b0;
        end else begin
            st_meta_q <= st;
            st_sync_q <= st_meta_q;
        end
    end

    // Debounce: accept a new level after it has differed for DEB_CYCLES cycles; pulse press on 0->1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q <= '0;
            deb_lvl_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (st_sync_q == deb_lvl_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_q <= st_sync_q;
                deb_cnt_q <= '0;
                press_q   <= st_sync_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
        end
    end

    // Next state, digit and prescaler logic; clr overrides any press.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        tick_cnt_d = tick_cnt_q;
        tick       = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);
        if (clr) begin
            state_d    = S_IDLE;
            digits_d   = '0;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_q) begin
                        state_d    = S_RUN;
                        tick_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        tick_cnt_d = '0;
                        if (digits_q == 16'h9999) begin
                            state_d = S_DONE;
                        end else begin
                            digits_d = bcd_inc(digits_q);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                    // A saturating tick ends the game even if a press lands in the same cycle.
                    if (press_q && (state_d == S_RUN)) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (press_q) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (press_q) begin
                        state_d  = S_IDLE;
                        digits_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, digits, prescaler and the registered state decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            digits_q   <= '0;
            tick_cnt_q <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            tick_cnt_q <= tick_cnt_d;
            running_q  <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Scan step: advance the digit index at the scan terminal count.
    always_comb begin
        scan_last = (scan_cnt_q == SCAN_LAST);
        pos_d     = scan_last ? pos_q + 2'd1 : pos_q;
    end

    // Free-running scan counter; num is loaded with the digit selected by the new pos.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            pos_q      <= 2'd0;
            num_q      <= 4'd0;
        end else begin
            scan_cnt_q <= scan_last ? '0 : scan_cnt_q + SW'(1);
            pos_q      <= pos_d;
            num_q      <= digits_q[{pos_d, 2'b00} +: 4];
        end
    end

    assign num     = num_q;
    assign pos     = pos_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with TICK_DIV=4, SCAN_DIV=2, DEB_CYCLES=3.
// A button press raised at negedge X takes effect at posedge X+6; a press
// started while the tick prescaler is 0 and paused P cycles later (P a multiple
// of 4, P>=12) adds exactly P/4 to the count and leaves the prescaler at 0.
`timescale 1ns/1ps

module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] num;
    logic [1:0] pos;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_bad    = 0;

    count_ctrl #(
        .TICK_DIV  (4),
        .SCAN_DIV  (2),
        .DEB_CYCLES(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .st     (st),
        .clr    (clr),
        .num    (num),
        .pos    (pos),
        .running(running),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: high 4 cycles, low 6 so the release is accepted before the next press.
    task automatic press();
        st = 1'b1;
        cyc(4);
        st = 1'b0;
        cyc(6);
    endtask

    // Start (or resume), then pause p cycles after the first press began.
    task automatic run_for(input int p);
        press();
        cyc(p - 10);
        press();
    endtask

    // Collect all four scanned digits over one full scan period (8 cycles).
    task automatic read_digits(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        logic [3:0]  seen;
        int          p;
        v    = '0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            p           = int'(pos);
            v[p*4 +: 4] = num;
            seen[p]     = 1'b1;
        end
        check({tag, " scan"}, 32'(seen), 32'h0000000f);
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        // Reset and idle scan
        cyc(5);
        check("rst running", 32'(running), 0);
        check("rst done", 32'(done), 0);
        check("rst num", 32'(num), 0);
        check("rst pos", 32'(pos), 0);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("idle pos", 32'(pos), 32'((k / 2) % 4));
            check("idle num", 32'(num), 0);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle run/done", 32'({running, done}), 0);
        end

        // Glitches shorter than the debounce window are ignored
        repeat (10) begin
            st = 1'b1;
            cyc(1);
            st = 1'b0;
            cyc(2);
        end
        cyc(6);
        check("glitch running", 32'(running), 0);

        // Clean edge: running rises exactly 6 cycles after st
        st = 1'b1;
        cyc(5);
        check("deb early", 32'(running), 0);
        cyc(1);
        check("deb latency", 32'(running), 1);
        st = 1'b0;
        cyc(36);
        press();
        check("pause running", 32'(running), 0);
        read_digits("pause digits", 16'h0010);
        cyc(50);
        read_digits("hold digits", 16'h0010);
        check("hold running", 32'(running), 0);

        // Resume from held prescaler, then pause on a tick cycle
        press();
        check("resume running", 32'(running), 1);
        press();
        check("repause running", 32'(running), 0);
        read_digits("resume digits", 16'h0013);

        // clr from PAUSE
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        check("clr running", 32'(running), 0);
        read_digits("clr digits", 16'h0000);

        // Carry chain and saturation
        run_for(36);
        read_digits("d0009", 16'h0009);
        run_for(12);
        read_digits("d0012", 16'h0012);
        run_for(348);
        read_digits("d0099", 16'h0099);
        run_for(12);
        read_digits("d0102", 16'h0102);
        run_for(39588);
        read_digits("d9999", 16'h9999);
        check("9999 done", 32'(done), 0);
        press();
        check("sat done", 32'(done), 1);
        check("sat running", 32'(running), 0);
        cyc(20);
        read_digits("sat digits", 16'h9999);
        check("sat done hold", 32'(done), 1);
        press();
        check("done->idle done", 32'(done), 0);
        check("done->idle running", 32'(running), 0);
        read_digits("done->idle digits", 16'h0000);

        // clr and press in the same cycle at 0057
        press();
        cyc(220);
        check("pre clr running", 32'(running), 1);
        st = 1'b1;
        cyc(4);
        st = 1'b0;
        cyc(1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(4);
        check("clr prio running", 32'(running), 0);
        read_digits("clr prio digits", 16'h0000);

        // Asynchronous reset mid-run at 0123
        press();
        cyc(490);
        check("pre rst running", 32'(running), 1);
        #2 rst = 1'b0;
        #1;
        check("async running", 32'(running), 0);
        check("async done", 32'(done), 0);
        check("async num", 32'(num), 0);
        check("async pos", 32'(pos), 0);
        #1 rst = 1'b1;
        cyc(3);
        check("post rst running", 32'(running), 0);
        read_digits("post rst digits", 16'h0000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
